// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and helpers for the memory-port arbiter
// Purpose: FSM state type, port-count ceiling and a width helper used for
//          the round-robin pointer and timeout counter.
package mem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int MEM_ARB_MAX_PORTS = 8;

    // Bits needed to hold 0..value-1, never less than one so that
    // degenerate sizes still give a legal vector.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and DRAM-side bundle of the memory-port arbiter
// Purpose: groups every non-clock/reset signal of mem_arbiter.
// Ports (slave = arbiter view):
//   in : mem_en, req_ip, we_ip, addr_ip, wdata_ip, be_ip, mem_rvalid_ip, mem_rdata_ip
//   out: gnt_op, rvalid_op, rdata_op, err_op, busy_op,
//        mem_req_op, mem_we_op, mem_addr_op, mem_wdata_op, mem_be_op
// The master modport is the environment (pipeline stages + DRAM) view.
interface mem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                               mem_en;
    logic [NUM_PORTS-1:0]               req_ip;
    logic [NUM_PORTS-1:0]               we_ip;
    logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr_ip;
    logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata_ip;
    logic [NUM_PORTS*DATA_WIDTH/8-1:0]  be_ip;
    logic [NUM_PORTS-1:0]               gnt_op;
    logic [NUM_PORTS-1:0]               rvalid_op;
    logic [DATA_WIDTH-1:0]              rdata_op;
    logic                               err_op;
    logic                               busy_op;
    logic                               mem_req_op;
    logic                               mem_we_op;
    logic [ADDR_WIDTH-1:0]              mem_addr_op;
    logic [DATA_WIDTH-1:0]              mem_wdata_op;
    logic [DATA_WIDTH/8-1:0]            mem_be_op;
    logic                               mem_rvalid_ip;
    logic [DATA_WIDTH-1:0]              mem_rdata_ip;

    modport slave (
        input  mem_en, req_ip, we_ip, addr_ip, wdata_ip, be_ip, mem_rvalid_ip, mem_rdata_ip,
        output gnt_op, rvalid_op, rdata_op, err_op, busy_op,
               mem_req_op, mem_we_op, mem_addr_op, mem_wdata_op, mem_be_op
    );

    modport master (
        output mem_en, req_ip, we_ip, addr_ip, wdata_ip, be_ip, mem_rvalid_ip, mem_rdata_ip,
        input  gnt_op, rvalid_op, rdata_op, err_op, busy_op,
               mem_req_op, mem_we_op, mem_addr_op, mem_wdata_op, mem_be_op
    );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational winner selection for mem_arbiter
// Purpose: picks one requester, either lowest index (fixed) or the first set
//          index at or above rr_ptr with wrap-around (round-robin).
// Ports:
//   req_i    in  NUM_PORTS  request vector
//   rr_ptr_i in  PW         round-robin start index (always < NUM_PORTS)
//   fixed_i  in  1          1 = fixed lowest-index priority
//   gnt_o    out NUM_PORTS  one-hot winner
//   idx_o    out PW         binary winner index
//   valid_o  out 1          any request present
module arb_rr_picker #(
    parameter int NUM_PORTS = 2,
    parameter int PW        = 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PW-1:0]        rr_ptr_i,
    input  logic                 fixed_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [PW-1:0]        idx_o,
    output logic                 valid_o
);
    always_comb begin : pick
        logic [PW:0] cand;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            // One extra bit so ptr+i cannot overflow before the explicit wrap;
            // after the wrap cand < NUM_PORTS, so the low PW bits are exact.
            cand = fixed_i ? (PW+1)'(i) : ({1'b0, rr_ptr_i} + (PW+1)'(i));
            if (cand >= (PW+1)'(NUM_PORTS)) begin
                cand = cand - (PW+1)'(NUM_PORTS);
            end
            if (!valid_o && req_i[cand[PW-1:0]]) begin
                valid_o               = 1'b1;
                gnt_o[cand[PW-1:0]]   = 1'b1;
                idx_o                 = cand[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-requester to single DRAM port arbiter, one outstanding transaction
// Purpose: 0-cycle grant in IDLE, waits in BUSY for the DRAM response or a
//          timeout, then routes the response pulse back to the owning port.
// Ports:
//   clock  in  core clock
//   reset  in  synchronous active-high reset
//   bus    mem_arbiter_if.slave (requester handshakes + DRAM port)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic           clock,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    localparam int PW = clog2_min1(NUM_PORTS);
    localparam int CW = clog2_min1(TIMEOUT_CYCLES);
    localparam int BW = DATA_WIDTH / 8;

    arb_state_e     state_q, state_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic           we_q, we_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [NUM_PORTS-1:0] pick_gnt;
    logic [PW-1:0]        pick_idx;
    logic                 pick_valid;

    logic [NUM_PORTS-1:0]  gnt_c, rvalid_c;
    logic [DATA_WIDTH-1:0] rdata_c, wdata_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [BW-1:0]         be_c;
    logic                  err_c, busy_c, req_c, we_c;

    arb_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_picker (
        .req_i    (bus.req_ip),
        .rr_ptr_i (rr_ptr_q),
        .fixed_i  (FIXED_PRIORITY != 0),
        .gnt_o    (pick_gnt),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        gnt_c    = '0;
        rvalid_c = '0;
        rdata_c  = '0;
        err_c    = 1'b0;
        busy_c   = 1'b0;
        req_c    = 1'b0;
        we_c     = 1'b0;
        addr_c   = '0;
        wdata_c  = '0;
        be_c     = '0;

        if (state_q == ARB_IDLE) begin
            if (bus.mem_en && pick_valid) begin
                gnt_c = pick_gnt;
                req_c = 1'b1;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (pick_gnt[i]) begin
                        we_c    = bus.we_ip[i];
                        addr_c  = bus.addr_ip[i*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_c = bus.wdata_ip[i*DATA_WIDTH +: DATA_WIDTH];
                        be_c    = bus.be_ip[i*BW +: BW];
                    end
                end
                owner_d  = pick_idx;
                we_d     = we_c;
                cnt_d    = '0;
                state_d  = ARB_BUSY;
                rr_ptr_d = (pick_idx == PW'(NUM_PORTS-1)) ? '0 : pick_idx + PW'(1);
            end
        end else begin
            busy_c = 1'b1;
            cnt_d  = cnt_q + CW'(1);
            // A real response beats a timeout landing in the same cycle.
            if (bus.mem_rvalid_ip) begin
                rvalid_c[owner_q] = 1'b1;
                rdata_c           = we_q ? '0 : bus.mem_rdata_ip;
                state_d           = ARB_IDLE;
                cnt_d             = '0;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
                rvalid_c[owner_q] = 1'b1;
                err_c             = 1'b1;
                state_d           = ARB_IDLE;
                cnt_d             = '0;
            end
        end

        // Outputs are forced quiet during reset so an aborted owner never
        // sees a response and no grant escapes in the reset cycle.
        if (reset) begin
            gnt_c    = '0;
            rvalid_c = '0;
            rdata_c  = '0;
            err_c    = 1'b0;
            busy_c   = 1'b0;
            req_c    = 1'b0;
            we_c     = 1'b0;
            addr_c   = '0;
            wdata_c  = '0;
            be_c     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.gnt_op       = gnt_c;
    assign bus.rvalid_op    = rvalid_c;
    assign bus.rdata_op     = rdata_c;
    assign bus.err_op       = err_c;
    assign bus.busy_op      = busy_c;
    assign bus.mem_req_op   = req_c;
    assign bus.mem_we_op    = we_c;
    assign bus.mem_addr_op  = addr_c;
    assign bus.mem_wdata_op = wdata_c;
    assign bus.mem_be_op    = be_c;

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (NUM_PORTS >= 2 && NUM_PORTS <= MEM_ARB_MAX_PORTS);
            assert ($onehot0(gnt_c));
            assert ($onehot0(rvalid_c));
            assert (!(state_q == ARB_BUSY && (|gnt_c)));
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised memory-port arbiter between N core requesters (IF fetch, LSU data, future DMA/debug) and a single DRAM port.
- Replaces the shared single grant line with per-port grant/response handshakes.
- Supports round-robin or fixed priority, one outstanding transaction, and a response timeout with error flag.
- Sits between the pipeline stages and DRAM in the core top level.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8); port 0 = fetch, port 1 = LSU.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8).
- FIXED_PRIORITY, 0, 1 = lowest index always wins; 0 = round-robin.
- TIMEOUT_CYCLES, 16, BUSY cycles without mem_rvalid_ip before abort (>=2).

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- mem_en  in  1  global enable; 0 blocks new grants, in-flight transaction completes
- req_ip  in  NUM_PORTS  per-port request, held until gnt
- we_ip  in  NUM_PORTS  per-port write enable
- addr_ip  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wdata_ip  in  NUM_PORTS*DATA_WIDTH  packed write data
- be_ip  in  NUM_PORTS*DATA_WIDTH/8  packed byte enables
- gnt_op  out  NUM_PORTS  one-hot grant pulse
- rvalid_op  out  NUM_PORTS  one-hot response pulse (read data or write ack)
- rdata_op  out  DATA_WIDTH  read data, valid with rvalid_op
- err_op  out  1  timeout error, pulses with rvalid_op
- busy_op  out  1  transaction outstanding (stall source)
- mem_req_op  out  1  request to DRAM
- mem_we_op  out  1  DRAM write enable
- mem_addr_op  out  ADDR_WIDTH  DRAM address
- mem_wdata_op  out  DATA_WIDTH  DRAM write data
- mem_be_op  out  DATA_WIDTH/8  DRAM byte enables
- mem_rvalid_ip  in  1  DRAM response valid
- mem_rdata_ip  in  DATA_WIDTH  DRAM read data

Behaviour:
- Reset (synchronous, active-high): state=ARB_IDLE, rr_ptr=0, owner=0, timeout counter=0. All outputs 0 in the reset cycle and in idle with no request.
- ARB_IDLE:
  - If mem_en=1 and |req_ip, pick a winner in the same cycle (combinational). gnt_op[winner]=1 and mem_req_op=1. mem_we/addr/wdata/be are muxed from the winner.
  - Latch owner and the winner's we; go to ARB_BUSY next cycle.
  - If mem_en=0, no grant and mem_req_op=0.
- Winner selection:
  - FIXED_PRIORITY=1: lowest set index.
  - Otherwise: first set index searching from rr_ptr upward with wrap-around.
  - After each grant, rr_ptr=(winner+1) mod NUM_PORTS. NUM_PORTS not a power of 2: wrap explicitly, never index past NUM_PORTS-1.
- ARB_BUSY:
  - busy_op=1, mem_req_op=0, counter increments each cycle.
  - mem_rvalid_ip=1: rvalid_op[owner]=1 that cycle (combinational). rdata_op=mem_rdata_ip for reads, 0 for writes. Return to ARB_IDLE and clear the counter.
  - If the counter reaches TIMEOUT_CYCLES-1 with no rvalid: rvalid_op[owner]=1, err_op=1, rdata_op=0, return to ARB_IDLE.
- Latency:
  - Grant is 0-cycle.
  - Minimum request-to-response is 1 cycle (DRAM answers the cycle after mem_req_op).
  - One idle bubble after each response: a new grant can occur no earlier than the cycle after rvalid.
- Requests are not accepted in ARB_BUSY; requesters hold req/addr/we/wdata/be until gnt. A req dropped before gnt is simply not granted.
- mem_rvalid_ip in ARB_IDLE is ignored. This covers late responses after a timeout or reset.
- Reset mid-transaction: abort immediately, no rvalid_op for the aborted owner, and a later stale mem_rvalid_ip is ignored.
- mem_en falling during ARB_BUSY does not abort; the response completes normally.
- Assertions: gnt_op and rvalid_op always $onehot0; gnt_op never asserted in ARB_BUSY.

Decomposition:
- Shared package MEM_ARB_PKG:
  - arb_state_e {ARB_IDLE, ARB_BUSY}
  - MEM_ARB_MAX_PORTS=8
  - function clog2_min1, for pointer and counter widths.
- Sub-module arb_rr_picker: combinational. Inputs req vector, rr_ptr, fixed mode. Outputs one-hot grant and binary index. Instantiated once.

Test Plan:
- Single read: port1 req, addr=0x80. gnt_op=2'b10 in the same cycle, mem_addr_op=0x80. DRAM returns 0xDEADBEEF one cycle later. rvalid_op=2'b10, rdata_op=0xDEADBEEF, err_op=0.
- Round-robin: ports 0 and 1 both request continuously, each served with 1-cycle latency. Grants alternate 0,1,0,1; exactly one idle cycle between rvalid and the next gnt.
- Fixed priority: FIXED_PRIORITY=1, NUM_PORTS=3, ports 1 and 2 request. Port 1 is granted first. Then port 0 requests while port 2 is still waiting; port 0 is granted next and port 2 waits.
- Timeout: grant port 0 and never assert mem_rvalid_ip. With TIMEOUT_CYCLES=16, rvalid_op[0]=1, err_op=1, rdata_op=0 exactly 16 cycles after gnt. A later stale mem_rvalid_ip produces no rvalid_op.
- Write ack: port 0 we=1, wdata=0x12345678, be=4'hF. mem_we_op=1 with matching data/be. On response, rvalid_op[0]=1 and rdata_op=0.
- Reset/enable: reset asserted in ARB_BUSY gives all outputs 0 next cycle, no rvalid_op, rr_ptr=0. mem_en=0 with req_ip=2'b11 gives no gnt_op for 5 cycles; mem_en=1 gives gnt to port 0.
